// File: rtl/div_seq_16bits.sv
// Sequential restoring divider: one quotient bit per clock, 17-cycle latency.
// Optional signed mode is enabled by defining DIV_SIGNED_EN.
module div_seq_16bits #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             busy_d;
  logic             done_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic; start is ignored while the done pulse is showing
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && !done) state_nx = RUN;
      RUN:  if (cnt == CW'(WIDTH - 1)) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // output / control decode
  always_comb begin
    load   = (state == IDLE) && start && !done;
    busy_d = (state == RUN);
    done_d = (state == FIN);
  end

  // one restoring step and the final result correction
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    qbit    = ~diff[WIDTH];
    op_a    = dividend;
    op_b    = divisor;
`ifdef DIV_SIGNED_EN
    if (dividend[WIDTH-1]) op_a = -dividend;
    if (divisor[WIDTH-1])  op_b = -divisor;
    q_res = neg_q ? -dvd : dvd;
    r_res = neg_r ? -rem : rem;
    if (dvs == '0) q_res = '1;
`else
    q_res = dvd;
    r_res = rem;
`endif
  end

  // datapath registers: operands, partial remainder, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else if (load) begin
      dvd <= op_a;
      dvs <= op_b;
      rem <= '0;
      cnt <= '0;
`ifdef DIV_SIGNED_EN
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
`endif
    end else if (state == RUN) begin
      rem <= qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      dvd <= {dvd[WIDTH-2:0], qbit};
      cnt <= cnt + CW'(1);
    end
  end

  // registered outputs, updated only when a result completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (done_d) begin
        quotient    <= q_res;
        remainder   <= r_res;
        div_by_zero <= (dvs == '0);
      end
    end
  end

endmodule

// File: tb/tb_div_seq_16bits.sv
// Directed bench for div_seq_16bits.
// Define DIV_SIGNED_EN to check the signed build.
module tb_div_seq_16bits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int errs = 0;
  int chks = 0;

  div_seq_16bits #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0 plain, 1 re-pulse start mid-run, 2 hold start during done
  task automatic run_div(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eq,
                         input logic [15:0] er, input logic ez,
                         input int mode);
    int k;
    int pulses;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy@N"}, busy, 1'b0);
    k = 0;
    pulses = 0;
    while (k < 40 && !done) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) check({tag, " busy@N+1"}, busy, 1'b1);
      if (mode == 1 && k == 4) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
      end
      if (mode == 1 && k == 5) start = 1'b0;
    end
    check({tag, " latency"}, k, 17);
    check({tag, " busy@done"}, busy, 1'b0);
    check({tag, " quot"}, quotient, eq);
    check({tag, " rem"}, remainder, er);
    check({tag, " dbz"}, div_by_zero, ez);
    if (done) pulses++;
    if (mode == 2) begin
      start    = 1'b1;
      dividend = 16'd50;
      divisor  = 16'd5;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) pulses++;
      if (mode == 2 && i == 1) check({tag, " ignored"}, busy, 1'b0);
    end
    check({tag, " pulses"}, pulses, 1);
    check({tag, " hold q"}, quotient, eq);
  endtask

  initial begin
    int seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst quot", quotient, 16'd0);
    check("rst rem", remainder, 16'd0);
    check("rst dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;

    run_div("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 0);
    run_div("ffff/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 0);
    run_div("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 0);
    run_div("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 0);
    run_div("repulse", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1);
    run_div("hold", 16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 2);
`ifdef DIV_SIGNED_EN
    run_div("-7/2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 0);
    run_div("min/-1", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 0);
`else
    run_div("fff9/2", 16'hFFF9, 16'd2, 16'h7FFC, 16'd1, 1'b0, 0);
    run_div("8000/ffff", 16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0, 0);
`endif

    // abort an operation with reset mid-run
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort quot", quotient, 16'd0);
    check("abort rem", remainder, 16'd0);
    check("abort dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("abort quiet", seen, 0);
    run_div("50/5", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/div_seq_16bits.md
DIV_SEQ_16BITS -- requirements
Module: div_seq_16bits

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits; only 16 is verified.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division, sampled on the rising edge of clk.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: the numerator, captured when start is accepted.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: the denominator, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when results are valid.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: registered quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: registered remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: set when the divisor of the last completed operation was zero.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch both operands, clear the partial remainder, load the iteration counter with 0, and enter RUN.
REQ-014 The block SHALL ignore start in RUN and DONE; operand changes during an operation SHALL have no effect.
REQ-015 RUN SHALL perform one restoring step per cycle: shift the next dividend MSB into the partial remainder, subtract the divisor using a WIDTH+1-bit difference, and keep the difference only if it is non-negative, writing a quotient bit of 1 in that case and 0 otherwise.
REQ-016 RUN SHALL last exactly WIDTH cycles (counter 0..15) and then enter DONE.
REQ-017 In DONE, the block SHALL register quotient, remainder and div_by_zero, pulse done for one cycle, and return to IDLE.
REQ-018 If start is accepted at edge N, done SHALL be high during the cycle following edge N+17; busy SHALL be high from edge N+1 until edge N+17.
REQ-019 A zero divisor SHALL follow the same timing and yield quotient=16'hFFFF, remainder=dividend and div_by_zero=1.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values until the next DONE state.
REQ-021 start asserted in the same cycle as the DONE pulse SHALL be ignored; it is accepted only on a later IDLE cycle.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, quotient=0, remainder=0 and div_by_zero=0, including in the middle of an operation.
REQ-023 After rst_n deasserts, the first start SHALL be accepted normally; no partial result from an aborted operation SHALL appear.

Configuration
REQ-024 When macro DIV_SIGNED_EN is defined, the block SHALL treat operands as two's complement: divide the magnitudes, truncate the quotient toward zero, and give the remainder the sign of the dividend, with the sign fix applied in DONE so latency is unchanged.
REQ-025 When DIV_SIGNED_EN is defined, 16'h8000 / 16'hFFFF SHALL return quotient=16'h8000 and remainder=0.
REQ-026 When DIV_SIGNED_EN is undefined, operands SHALL be unsigned and no sign logic SHALL be present.

Verification
REQ-027 dividend=100, divisor=7, start pulse -> done 17 cycles later, quotient=14, remainder=2, div_by_zero=0.
REQ-028 dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-029 dividend=1234, divisor=0 -> done at cycle 17, quotient=16'hFFFF, remainder=1234, div_by_zero=1.
REQ-030 start re-pulsed at cycle 5 with new operands (100/7 running) -> result still 14 r 2, single done pulse.
REQ-031 rst_n low at cycle 8 of an operation -> all outputs 0 immediately, no done; a new start of 50/5 then gives quotient=10, remainder=0.
REQ-032 With DIV_SIGNED_EN: dividend=-7 (16'hFFF9), divisor=2 -> quotient=16'hFFFD (-3), remainder=16'hFFFF (-1).
